// File: rtl/alu_arbiter_if.sv
// Signals between alu_arbiter, its two requesters, the shared ALU and the response consumers.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              req0_valid_i, req1_valid_i;
  logic              req0_ready_o, req1_ready_o;
  logic [AWIDTH-1:0] req0_pc_i, req1_pc_i;
  logic [DWIDTH-1:0] req0_rs1_i, req1_rs1_i;
  logic [DWIDTH-1:0] req0_rs2_i, req1_rs2_i;
  logic [3:0]        req0_alusel_i, req1_alusel_i;
  logic [AWIDTH-1:0] alu_pc_o;
  logic [DWIDTH-1:0] alu_rs1_o;
  logic [DWIDTH-1:0] alu_rs2_o;
  logic [3:0]        alu_alusel_o;
  logic [DWIDTH-1:0] alu_res_i;
  logic              rsp0_valid_o, rsp1_valid_o;
  logic [DWIDTH-1:0] rsp0_data_o, rsp1_data_o;
  logic              rsp0_ready_i, rsp1_ready_i;
  logic              busy_o;

  modport slave (
    input  req0_valid_i, req1_valid_i,
    output req0_ready_o, req1_ready_o,
    input  req0_pc_i, req1_pc_i, req0_rs1_i, req1_rs1_i,
    input  req0_rs2_i, req1_rs2_i, req0_alusel_i, req1_alusel_i,
    output alu_pc_o, alu_rs1_o, alu_rs2_o, alu_alusel_o,
    input  alu_res_i,
    output rsp0_valid_o, rsp1_valid_o, rsp0_data_o, rsp1_data_o,
    input  rsp0_ready_i, rsp1_ready_i,
    output busy_o
  );

  modport master (
    output req0_valid_i, req1_valid_i,
    input  req0_ready_o, req1_ready_o,
    output req0_pc_i, req1_pc_i, req0_rs1_i, req1_rs1_i,
    output req0_rs2_i, req1_rs2_i, req0_alusel_i, req1_alusel_i,
    input  alu_pc_o, alu_rs1_o, alu_rs2_o, alu_alusel_o,
    output alu_res_i,
    input  rsp0_valid_o, rsp1_valid_o, rsp0_data_o, rsp1_data_o,
    output rsp0_ready_i, rsp1_ready_i,
    input  busy_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one execute-stage ALU between two requesters: operands are latched
// on accept, the ALU result is registered and returned on the winner's response channel.
module alu_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              prio, owner, grant, accept, rsp_done, vld_p1;
  logic [AWIDTH-1:0] pc_p0;
  logic [DWIDTH-1:0] rs1_p0, rs2_p0, res_p1;
  logic [3:0]        alusel_p0;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0_valid_i || bus.req1_valid_i) begin
          // prio only breaks ties; a lone requester always wins
          grant     = (bus.req0_valid_i && bus.req1_valid_i) ? prio : bus.req1_valid_i;
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (owner ? bus.rsp1_ready_i : bus.rsp0_ready_i) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      prio  <= 1'b0;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)   owner <= grant;
      if (rsp_done) prio  <= ~owner;
    end
  end

  // Stage p0: operands of the granted requester, held until the next accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0     <= '0;
      rs1_p0    <= '0;
      rs2_p0    <= '0;
      alusel_p0 <= '0;
    end else if (accept) begin
      pc_p0     <= grant ? bus.req1_pc_i     : bus.req0_pc_i;
      rs1_p0    <= grant ? bus.req1_rs1_i    : bus.req0_rs1_i;
      rs2_p0    <= grant ? bus.req1_rs2_i    : bus.req0_rs2_i;
      alusel_p0 <= grant ? bus.req1_alusel_i : bus.req0_alusel_i;
    end
  end

  // Stage p1: ALU result captured at the end of EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_p1 <= '0;
    end else if (state == EXEC) begin
      res_p1 <= bus.alu_res_i;
    end
  end

  assign vld_p1 = (state == RESP);

  // Ready is masked during reset so nothing can look accepted while state is being cleared
  assign bus.req0_ready_o = accept && !grant && !reset;
  assign bus.req1_ready_o = accept &&  grant && !reset;

  assign bus.alu_pc_o     = pc_p0;
  assign bus.alu_rs1_o    = rs1_p0;
  assign bus.alu_rs2_o    = rs2_p0;
  assign bus.alu_alusel_o = alusel_p0;

  assign bus.rsp0_valid_o = vld_p1 && !owner;
  assign bus.rsp1_valid_o = vld_p1 &&  owner;
  assign bus.rsp0_data_o  = res_p1;
  assign bus.rsp1_data_o  = res_p1;
  assign bus.busy_o       = (state != IDLE);
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single execute-stage ALU between two requesters, for example the main pipeline and a multi-cycle address/branch helper. Each requester presents an operation over a valid/ready handshake. The arbiter picks one requester using round-robin, drives the latched operands into the ALU, and registers the ALU result. It then returns the result to the winning requester over a per-requester valid/ready response channel.

## Interface
- DWIDTH, 32, data width of operands and result
- AWIDTH, 32, PC width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req0_valid_i / req1_valid_i  in  1  requester k has an operation pending
- req0_ready_o / req1_ready_o  out  1  operation from requester k accepted this cycle
- req0_pc_i / req1_pc_i  in  AWIDTH  PC operand
- req0_rs1_i / req1_rs1_i  in  DWIDTH  first operand
- req0_rs2_i / req1_rs2_i  in  DWIDTH  second operand (register value or immediate)
- req0_alusel_i / req1_alusel_i  in  4  ALU operation select (team ALUSEL encoding)
- alu_pc_o  out  AWIDTH  latched PC to ALU
- alu_rs1_o  out  DWIDTH  latched rs1 to ALU
- alu_rs2_o  out  DWIDTH  latched rs2 to ALU
- alu_alusel_o  out  4  latched ALUSEL to ALU
- alu_res_i  in  DWIDTH  combinational ALU result
- rsp0_valid_o / rsp1_valid_o  out  1  result for requester k is available
- rsp0_data_o / rsp1_data_o  out  DWIDTH  registered result
- rsp0_ready_i / rsp1_ready_i  in  1  requester k consumes the result
- busy_o  out  1  high whenever the state is not IDLE

## Operation
- FSM states are IDLE, EXEC and RESP. Reset enters IDLE.
- IDLE:
  - If no valid is asserted, stay in IDLE.
  - Otherwise the grant goes to the single valid requester. If both are valid, the grant goes to the requester selected by prio (prio=0 means req0 wins).
  - reqk_ready_o is asserted combinationally for the granted k only. It is never asserted in EXEC or RESP.
  - On the accept edge (valid and ready): latch pc, rs1, rs2, alusel and the owner index (owner=k). Next state is EXEC.
- EXEC:
  - alu_*_o carry the latched operands; they are always driven from the operand registers.
  - On the edge, capture alu_res_i into the result register. Next state is RESP.
- RESP:
  - rsp{owner}_valid_o=1 and rsp{owner}_data_o=result. The other response channel keeps valid=0.
  - Hold this state until rsp{owner}_ready_i=1. On that edge: prio becomes the inverse of owner, and next state is IDLE.
- rspk_data_o always shows the result register; only the valid bit is gated.
- A requester must hold valid and its operands stable until ready. Operands may change freely after acceptance.
- No data transformation is performed; the result is alu_res_i bit-exact.

## Timing
- Reset values:
  - State IDLE, prio=0, owner=0.
  - Operand, ALUSEL and result registers are 0, so alu_*_o=0 and rsp*_data_o=0.
  - All ready, valid and busy outputs are 0.
- Latency: accept at edge N, result captured at N+1, rsp valid high during the cycle after N+1.
- Throughput: one operation per 3 cycles when the response ready is held high. There is no back-to-back accept from RESP; it must return through IDLE.
- Simultaneous requests are resolved by prio only. prio updates only at response completion, so alternation is guaranteed when both requesters stay valid.
- Response stall: RESP holds data and valid indefinitely. No new request is accepted meanwhile, and the other requester waits.
- A valid that deasserts before acceptance is a protocol violation. The arbiter behaviour then is simply "not granted"; no state changes.
- Reset mid-operation (any state): the transaction is dropped, all state returns to reset values immediately (asynchronous), and no response is issued.
- rsp*_ready_i asserted outside RESP, or by the non-owner, is ignored.

## Test plan
- Single request: req0 with alusel=ADD, rs1=5, rs2=7 and rsp0_ready=1. Required response: req0_ready for 1 cycle, rsp0_valid 2 cycles after accept with data=12, and rsp1_valid stays 0.
- Contention: req0 and req1 held valid continuously, req0 SUB 10-3, req1 XOR 0xF0^0x0F, both rsp ready high. Required response: grants in order req0, req1, req0, req1 with results 7 and 0xFF; each result is on its own channel only.
- Response backpressure: req1 SLT -1<1 with rsp1_ready=0 for 5 cycles. Required response: rsp1_valid and data=1 held stable, busy_o=1, req0 requests not accepted; completion on the first ready cycle, then req0 is served next.
- Operand latching: req0 SRA 0x80000000 by 4. Change the req0 inputs the cycle after accept. Required response: result is 0xF8000000 and alu_*_o stay constant through EXEC.
- Reset in EXEC and in RESP. Required response: all outputs return to 0 asynchronously, with no response issued. After release, prio=0, so simultaneous requests grant req0.
- Ignore stray ready: in IDLE with no requests, assert rsp0_ready and rsp1_ready. Required response: no state change, all valids 0, busy_o=0.
